// File: rtl/mdu_ctrl_if.sv
// rtl/mdu_ctrl_if.sv - E-stage request and HI/LO result bus between the pipeline and mdu_ctrl
interface mdu_ctrl_if;
  logic [3:0]  op;
  logic        valid;
  logic        flush;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic        busy;
  logic [31:0] out;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output op, valid, flush, A, B,
    input  start, busy, out, HI, LO
  );

  modport slave (
    input  op, valid, flush, A, B,
    output start, busy, out, HI, LO
  );
endinterface

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multiply/divide sequencer owning HI/LO; optional MDU_ABORT_EN lets flush abort a running op
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic [0:0]    state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hi_q, lo_q;
  logic [31:0]   phi_q, plo_q;
  logic          dz_q;

  logic          busy_q;
  logic          is_mul, is_div, is_signed;
  logic          start_int;
  logic          accept;
  logic          abort;

  logic [63:0]   mul_a, mul_b, product;
  logic          a_neg, b_neg;
  logic [31:0]   a_mag, b_mag, b_safe;
  logic [31:0]   q_mag, r_mag;
  logic [31:0]   quot, rem;
  logic [31:0]   res_hi, res_lo;

  assign busy_q    = (state_q == S_RUN);
  assign is_mul    = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
  assign is_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
  assign is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);

  assign accept    = bus.valid & ~bus.flush & ~busy_q;
  assign start_int = accept & (is_mul | is_div);

  assign bus.start = start_int;
  assign bus.busy  = busy_q;
  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;

  always_comb begin
    bus.out = 32'd0;
    if (bus.op == OP_MFHI)
      bus.out = hi_q;
    else if (bus.op == OP_MFLO)
      bus.out = lo_q;
  end

  // Sign-extended 64-bit operands give the right low 64 product bits for both signed and unsigned.
  assign mul_a   = is_signed ? {{32{bus.A[31]}}, bus.A} : {32'd0, bus.A};
  assign mul_b   = is_signed ? {{32{bus.B[31]}}, bus.B} : {32'd0, bus.B};
  assign product = mul_a * mul_b;

  // One unsigned divider on magnitudes; signs are restored afterwards, which also makes
  // 0x80000000 / -1 come out as LO=0x80000000, HI=0 without a special case.
  assign a_neg  = is_signed & bus.A[31];
  assign b_neg  = is_signed & bus.B[31];
  assign a_mag  = a_neg ? (~bus.A + 32'd1) : bus.A;
  assign b_mag  = b_neg ? (~bus.B + 32'd1) : bus.B;
  assign b_safe = (bus.B == 32'd0) ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem    = a_neg ? (~r_mag + 32'd1) : r_mag;

  assign res_hi = is_div ? rem  : product[63:32];
  assign res_lo = is_div ? quot : product[31:0];

`ifdef MDU_ABORT_EN
  assign abort = bus.flush;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_int) begin
            phi_q   <= res_hi;
            plo_q   <= res_lo;
            dz_q    <= is_div & (bus.B == 32'd0);
            cnt_q   <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            state_q <= S_RUN;
          end else if (accept) begin
            if (bus.op == OP_MTHI)
              hi_q <= bus.A;
            if (bus.op == OP_MTLO)
              lo_q <= bus.A;
          end
        end
        S_RUN: begin
          // The completing edge commits even when an abort-capable flush lands on it.
          if (cnt_q == CW'(1)) begin
            if (!dz_q) begin
              hi_q <= phi_q;
              lo_q <= plo_q;
            end
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else if (abort) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - self-checking bench for mdu_ctrl with a behavioural HI/LO model
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mdu_ctrl_if bus();

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining busy cycles plus the value that will land in HI/LO.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  int          m_left = 0;
  bit          m_ok = 1'b0;

  always @(posedge clk or negedge reset) begin : model
    longint a, b, q, r;
    logic [63:0] prod;
    bit abort;
    if (!reset) begin
      m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; m_left = 0; m_ok = 0;
    end else if (m_left > 0) begin
      abort = 1'b0;
`ifdef MDU_ABORT_EN
      abort = bus.flush && (m_left != 1);
`endif
      if (abort) begin
        m_left = 0;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0 && m_ok) begin
          m_hi = p_hi;
          m_lo = p_lo;
        end
      end
    end else if (bus.valid && !bus.flush) begin
      case (bus.op)
        4'd1, 4'd3: begin
          a = longint'($signed(bus.A));
          b = longint'($signed(bus.B));
        end
        default: begin
          a = longint'({32'd0, bus.A});
          b = longint'({32'd0, bus.B});
        end
      endcase
      case (bus.op)
        4'd1, 4'd2: begin
          prod = 64'(a * b);
          p_hi = prod[63:32];
          p_lo = prod[31:0];
          m_ok = 1'b1;
          m_left = MC;
        end
        4'd3, 4'd4: begin
          m_left = DC;
          if (bus.B == 32'd0) begin
            m_ok = 1'b0;
          end else begin
            q = a / b;
            r = a % b;
            p_lo = q[31:0];
            p_hi = r[31:0];
            m_ok = 1'b1;
          end
        end
        4'd5: m_hi = bus.A;
        4'd6: m_lo = bus.A;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] e_out;
    logic e_start;
    e_out   = (bus.op == 4'd7) ? m_hi : (bus.op == 4'd8) ? m_lo : 32'd0;
    e_start = bus.valid && !bus.flush && (m_left == 0) && (bus.op >= 4'd1) && (bus.op <= 4'd4);
    chk("cyc_busy",  {31'd0, bus.busy},  {31'd0, (m_left > 0)});
    chk("cyc_start", {31'd0, bus.start}, {31'd0, e_start});
    chk("cyc_out",   bus.out, e_out);
    chk("cyc_hi",    bus.HI,  m_hi);
    chk("cyc_lo",    bus.LO,  m_lo);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic v, input logic f,
                       input logic [31:0] a, input logic [31:0] b);
    bus.op = op; bus.valid = v; bus.flush = f; bus.A = a; bus.B = b;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      step();
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int exp_cycles);
    int n;
    drive(op, 1'b1, 1'b0, a, b);
    step();
    drive(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_idle(n);
    chk(name, n, exp_cycles);
  endtask

  initial begin
    int n;
    drive(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    step();
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_hi", bus.HI, 32'd0);
    chk("rst_lo", bus.LO, 32'd0);
    reset = 1'b1;
    step();

    run_op("mult_cycles", 4'd1, 32'hFFFFFFFD, 32'd5, 5);
    chk("mult_hi", bus.HI, 32'hFFFFFFFF);
    chk("mult_lo", bus.LO, 32'hFFFFFFF1);

    run_op("multu_cycles", 4'd2, 32'hFFFFFFFD, 32'd5, 5);
    chk("multu_hi", bus.HI, 32'h00000004);
    chk("multu_lo", bus.LO, 32'hFFFFFFF1);

    run_op("div_cycles", 4'd3, 32'hFFFFFFF9, 32'd2, 10);
    chk("div_hi", bus.HI, 32'hFFFFFFFF);
    chk("div_lo", bus.LO, 32'hFFFFFFFD);

    run_op("divu_cycles", 4'd4, 32'd7, 32'd2, 10);
    chk("divu_hi", bus.HI, 32'd1);
    chk("divu_lo", bus.LO, 32'd3);

    run_op("divovf_cycles", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10);
    chk("divovf_hi", bus.HI, 32'd0);
    chk("divovf_lo", bus.LO, 32'h80000000);

    drive(4'd5, 1'b1, 1'b0, 32'h12345678, 32'd0);
    step();
    drive(4'd7, 1'b1, 1'b0, 32'd0, 32'd0);
    #1;
    chk("mfhi_out", bus.out, 32'h12345678);
    step();
    drive(4'd6, 1'b1, 1'b0, 32'h9ABCDEF0, 32'd0);
    step();
    drive(4'd8, 1'b1, 1'b0, 32'd0, 32'd0);
    #1;
    chk("mflo_out", bus.out, 32'h9ABCDEF0);
    step();

    run_op("divz_cycles", 4'd3, 32'd5, 32'd0, 10);
    chk("divz_hi", bus.HI, 32'h12345678);
    chk("divz_lo", bus.LO, 32'h9ABCDEF0);

    drive(4'd1, 1'b1, 1'b1, 32'd3, 32'd5);
    #1;
    chk("flush_start", {31'd0, bus.start}, 32'd0);
    step();
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    drive(4'd6, 1'b1, 1'b1, 32'hFFFF0000, 32'd0);
    step();
    drive(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("flush_hi", bus.HI, 32'h12345678);
    chk("flush_lo", bus.LO, 32'h9ABCDEF0);
    step();

    drive(4'd5, 1'b1, 1'b0, 32'hAAAA5555, 32'd0);
    step();
    drive(4'd6, 1'b1, 1'b0, 32'h5555AAAA, 32'd0);
    step();
    drive(4'd1, 1'b1, 1'b0, 32'h00010000, 32'h00010000);
    step();
    drive(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    drive(4'd0, 1'b0, 1'b1, 32'd0, 32'd0);
    step();
    drive(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
`ifdef MDU_ABORT_EN
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_hi", bus.HI, 32'hAAAA5555);
    chk("abort_lo", bus.LO, 32'h5555AAAA);
`else
    wait_idle(n);
    chk("noabort_rest", n, 3);
    chk("noabort_hi", bus.HI, 32'd1);
    chk("noabort_lo", bus.LO, 32'd0);
`endif
    step();

    drive(4'd4, 1'b1, 1'b0, 32'd7, 32'd2);
    step();
    drive(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rstrun_busy", {31'd0, bus.busy}, 32'd0);
    chk("rstrun_hi", bus.HI, 32'd0);
    chk("rstrun_lo", bus.LO, 32'd0);
    step();
    step();
    reset = 1'b1;
    repeat (12) step();
    chk("rstpost_busy", {31'd0, bus.busy}, 32'd0);
    chk("rstpost_hi", bus.HI, 32'd0);
    chk("rstpost_lo", bus.LO, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

- Sequences the multiply/divide unit (MDU) in the E stage of the P7 five-stage pipeline.
- Owns the HI/LO registers and accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from E.
- Times multi-cycle operations and reports `start`/`busy` to the stall unit.
- Honours the exception flush so a victim instruction never alters HI/LO.

## Interface
Parameters:
- `MULT_CYCLES`, 5, busy duration of mult/multu (≥1)
- `DIV_CYCLES`, 10, busy duration of div/divu (≥1)

Ports:
- `clk`  in  1  pipeline clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset)
- `op`  in  4  E-stage MDU op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9–15 treated as none
- `valid`  in  1  E-stage instruction is real (not a bubble)
- `flush`  in  1  exception/interrupt flush of the E-stage instruction this cycle
- `A`  in  32  forwarded rs value
- `B`  in  32  forwarded rt value
- `start`  out  1  combinational: `valid & ~flush & ~busy & op∈{1..4}`
- `busy`  out  1  registered: multi-cycle operation in flight
- `out`  out  32  combinational: HI if op=7, LO if op=8, else 0
- `HI`, `LO`  out  32 each  architectural registers

## Operation
- Two states: IDLE (`busy`=0), RUN (`busy`=1).
- IDLE, `start`=1:
  - latch op-specific result into pending registers `pHI`/`pLO`;
  - load `cnt` with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- RUN: `cnt` decrements each edge. On the edge where `cnt`=1: copy `pHI`/`pLO` to HI/LO (unless div-by-zero flag set), go to IDLE.
- Results, computed from A/B at start:
  - mult: signed 64-bit product; multu: unsigned 64-bit product; HI = bits 63:32, LO = bits 31:0.
  - div: signed, quotient truncated toward zero to LO; remainder to HI, sign follows dividend.
  - divu: unsigned quotient to LO, remainder to HI.
  - B=0 on div/divu: sets div-by-zero flag; op still runs full DIV_CYCLES; HI/LO unchanged at completion.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo: when `valid & ~flush & ~busy`, HI (or LO) ← A at the next edge. No busy.
- mfhi/mflo: read only, no state change.
- `start` or mt* while busy: ignored. The stall unit prevents this; the behaviour is defined anyway.
- `flush`=1 suppresses `start` and mt* writes in that cycle.

## Timing
- Reset (asynchronous, `reset`=0): state IDLE, `busy`=0, `cnt`=0, HI=LO=0, pending regs 0. `start`/`out` follow inputs combinationally.
- Start at edge T: `busy`=1 from T through T+N−1. HI/LO show the result after edge T+N, where `busy` falls. N is MULT_CYCLES or DIV_CYCLES.
- mt* in cycle C: HI/LO updated after the edge ending C.
- Back-to-back: a new start is accepted in the first cycle `busy`=0.
- Reset asserted mid-RUN: immediate IDLE, HI/LO cleared, result discarded.
- `flush` coincident with the completing edge: completion wins; HI/LO are written.

## Configuration
- `MDU_ABORT_EN` defined:
  - `flush`=1 while in RUN aborts the in-flight operation;
  - next edge returns to IDLE, `busy`=0, HI/LO keep pre-operation values;
  - exception: the completing edge (`cnt`=1) still commits.
- `MDU_ABORT_EN` undefined: `flush` only gates new start and mt* writes; a running operation always completes and commits.

## Test plan
- mult A=0xFFFFFFFD (−3), B=5 → `busy` high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1. multu same operands → HI=0x00000004, LO=0xFFFFFFF1.
- div A=0xFFFFFFF9 (−7), B=2 → 10 busy cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 → LO=3, HI=1.
- mthi A=0x12345678, then mfhi next cycle → `out`=0x12345678. div by B=0 → HI/LO unchanged after 10 busy cycles.
- valid mult with `flush`=1 → `start`=0, `busy` never rises, HI/LO unchanged. mtlo with `flush`=1 → LO unchanged.
- `MDU_ABORT_EN`: mult started, `flush` at busy cycle 2 → `busy`=0 next cycle, HI/LO equal prior values. Without the macro: same stimulus → full 5 cycles, result committed.
- `reset`=0 during busy cycle 3 of divu → `busy`=0 and HI=LO=0 immediately (before the next edge); no commit after release.
